// File: rtl/hsc_tdc_buf.sv
// ============================================================================
// Module : hsc_tdc_buf
// Buffer-delay-line TDC: a launched edge is captured across N_TAPS preserved
// buffer taps and reduced to a registered Hamming weight with an aligned valid.
// Option : define HSC_TDC_INT_TOG_EN to drive the toggle source from an
//          internal period-4 counter instead of the pg_tog port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hsc_tdc_buf #(
  parameter int N_TAPS = 127,
  parameter int HW_W   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pg_in,
  input  logic            pg_tog,
  input  logic            pg_src,
  input  logic            pg_bypass,
  input  logic            val_in,
  output logic [HW_W-1:0] hw,
  output logic            val_out
);

  logic            tog_src;
  logic            pg_sel;
  logic            pg_d, pg_q;
  logic            launch;
  logic [N_TAPS-1:0] cap_d, cap_q;
  logic [HW_W-1:0] hw_d, hw_q;
  logic [2:0]      val_pipe_d, val_pipe_q;

  // The tap nets model physical buffer stages; they must survive synthesis so
  // each capture flop sees a distinct propagation delay.
  (* keep = "true", dont_touch = "true" *) logic [N_TAPS-1:0] tap;

`ifdef HSC_TDC_INT_TOG_EN
  logic [1:0] tog_cnt_d, tog_cnt_q;
  logic       unused_pg_tog;

  assign unused_pg_tog = pg_tog;
  assign tog_src       = tog_cnt_q[1];

  always_comb begin
    tog_cnt_d = tog_cnt_q + 2'd1;
    if (rst) tog_cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    tog_cnt_q <= tog_cnt_d;
  end
`else
  assign tog_src = pg_tog;
`endif

  assign pg_sel = pg_src ? tog_src : pg_in;
  assign launch = pg_bypass ? pg_sel : pg_q;

  always_comb begin
    tap[0] = launch;
    for (int i = 1; i < N_TAPS; i++) begin
      tap[i] = tap[i-1];
    end
  end

  always_comb begin
    pg_d       = pg_sel;
    cap_d      = tap;
    val_pipe_d = {val_pipe_q[1:0], val_in};
    hw_d       = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      hw_d = hw_d + HW_W'(cap_q[i]);
    end
    if (rst) begin
      pg_d       = 1'b0;
      cap_d      = '0;
      val_pipe_d = 3'b000;
      hw_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    pg_q       <= pg_d;
    cap_q      <= cap_d;
    hw_q       <= hw_d;
    val_pipe_q <= val_pipe_d;
  end

  // Bypass removes one register from the data path, so tap the valid one earlier.
  assign hw      = hw_q;
  assign val_out = pg_bypass ? val_pipe_q[1] : val_pipe_q[2];

endmodule

`default_nettype wire

// File: tb/tb_hsc_tdc_buf.sv
// ============================================================================
// Module : tb_hsc_tdc_buf
// Directed self-checking bench for hsc_tdc_buf (HSC_TDC_INT_TOG_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hsc_tdc_buf;

  localparam int N_TAPS = 127;
  localparam int HW_W   = 7;
  localparam logic [HW_W-1:0] FULL = 7'd127;

  logic            clk = 1'b0;
  logic            rst;
  logic            pg_in;
  logic            pg_tog;
  logic            pg_src;
  logic            pg_bypass;
  logic            val_in;
  logic [HW_W-1:0] hw;
  logic            val_out;

  int total = 0;
  int bad   = 0;

  hsc_tdc_buf #(.N_TAPS(N_TAPS), .HW_W(HW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pg_in     (pg_in),
    .pg_tog    (pg_tog),
    .pg_src    (pg_src),
    .pg_bypass (pg_bypass),
    .val_in    (val_in),
    .hw        (hw),
    .val_out   (val_out)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pg_in = 1'b1; pg_tog = 1'b0; pg_src = 1'b0;
    pg_bypass = 1'b0; val_in = 1'b1;
    flush(2);
    total++;
    if (hw !== 7'd0) begin bad++; $display("FAIL reset_hw: got %0d want 0", hw); end
    total++;
    if (val_out !== 1'b0) begin bad++; $display("FAIL reset_val: got %b want 0", val_out); end
    rst = 1'b0; pg_in = 1'b0; val_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (hw !== 7'd0) begin bad++; $display("FAIL reset_release_hw[%0d]: got %0d want 0", i, hw); end
    end
  endtask

  task automatic test_bypass();
    pg_src = 1'b0; pg_bypass = 1'b1; pg_in = 1'b0; val_in = 1'b0;
    flush(3);
    pg_in = 1'b1; val_in = 1'b1;
    tick();  // edge k
    val_in = 1'b0;
    total++;
    if (hw !== 7'd0) begin bad++; $display("FAIL bypass_k_hw: got %0d want 0", hw); end
    tick();  // edge k+1
    total++;
    if (hw !== FULL) begin bad++; $display("FAIL bypass_k1_hw: got %0d want 127", hw); end
    total++;
    if (val_out !== 1'b1) begin bad++; $display("FAIL bypass_k1_val: got %b want 1", val_out); end
    tick();
    total++;
    if (val_out !== 1'b0) begin bad++; $display("FAIL bypass_k2_val: got %b want 0", val_out); end
    total++;
    if (hw !== FULL) begin bad++; $display("FAIL bypass_k2_hw: got %0d want 127", hw); end
    pg_in = 1'b0;
    flush(3);
  endtask

  task automatic test_sync();
    pg_src = 1'b0; pg_bypass = 1'b0; pg_in = 1'b0; val_in = 1'b0;
    flush(4);
    pg_in = 1'b1; val_in = 1'b1;
    tick();  // edge k
    val_in = 1'b0;
    total++;
    if (hw !== 7'd0 || val_out !== 1'b0) begin
      bad++; $display("FAIL sync_k: got hw=%0d val=%b want hw=0 val=0", hw, val_out);
    end
    tick();  // edge k+1
    total++;
    if (hw !== 7'd0 || val_out !== 1'b0) begin
      bad++; $display("FAIL sync_k1: got hw=%0d val=%b want hw=0 val=0", hw, val_out);
    end
    tick();  // edge k+2
    total++;
    if (hw !== FULL || val_out !== 1'b1) begin
      bad++; $display("FAIL sync_k2: got hw=%0d val=%b want hw=127 val=1", hw, val_out);
    end
    tick();
    total++;
    if (hw !== FULL || val_out !== 1'b0) begin
      bad++; $display("FAIL sync_k3: got hw=%0d val=%b want hw=127 val=0", hw, val_out);
    end
    pg_in = 1'b0;
    tick();
    tick();
    total++;
    if (hw !== FULL) begin bad++; $display("FAIL sync_fall_early: got %0d want 127", hw); end
    tick();
    total++;
    if (hw !== 7'd0) begin bad++; $display("FAIL sync_fall: got %0d want 0", hw); end
  endtask

`ifndef HSC_TDC_INT_TOG_EN
  task automatic test_toggle();
    logic [3:0] pat;
    logic [15:0] hist;
    pat = 4'b1100;  // index 0..3 -> 0,0,1,1
    hist = '0;
    pg_src = 1'b1; pg_bypass = 1'b0; pg_tog = 1'b0; val_in = 1'b0;
    flush(4);
    for (int j = 0; j < 12; j++) begin
      pg_tog = pat[j % 4];
      hist[j] = pat[j % 4];
      tick();
      if (j >= 2) begin
        total++;
        if (hw !== (hist[j-2] ? FULL : 7'd0)) begin
          bad++; $display("FAIL toggle[%0d]: got %0d want %0d", j, hw, hist[j-2] ? 127 : 0);
        end
      end
    end
    pg_tog = 1'b0;
  endtask
`endif

  task automatic test_midreset();
    pg_src = 1'b0; pg_bypass = 1'b0; pg_in = 1'b1; val_in = 1'b1;
    flush(4);
    total++;
    if (hw !== FULL || val_out !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: got hw=%0d val=%b want hw=127 val=1", hw, val_out);
    end
    rst = 1'b1;
    tick();
    total++;
    if (hw !== 7'd0 || val_out !== 1'b0) begin
      bad++; $display("FAIL midrst_clear: got hw=%0d val=%b want hw=0 val=0", hw, val_out);
    end
    rst = 1'b0; val_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (hw !== ((i == 3) ? FULL : 7'd0)) begin
        bad++; $display("FAIL midrst_release[%0d]: got %0d want %0d", i, hw, (i == 3) ? 127 : 0);
      end
    end
  endtask

`ifdef HSC_TDC_INT_TOG_EN
  task automatic test_int_tog();
    logic want;
    pg_src = 1'b1; pg_bypass = 1'b1; pg_tog = 1'b0; pg_in = 1'b0; val_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Counter is 0 before post-reset edge 1; source high when (j-1)%4 >= 2.
    for (int j = 1; j <= 13; j++) begin
      tick();
      if (j >= 2) begin
        want = ((j - 2) % 4) >= 2;
        total++;
        if (hw !== (want ? FULL : 7'd0)) begin
          bad++; $display("FAIL int_tog[%0d]: got %0d want %0d", j, hw, want ? 127 : 0);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bypass();
    test_sync();
`ifndef HSC_TDC_INT_TOG_EN
    test_toggle();
`endif
    test_midreset();
`ifdef HSC_TDC_INT_TOG_EN
    test_int_tog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
